// File: rtl/proj_pkg.sv
// rtl/proj_pkg.sv - shared constants and FSM encoding for the projection sweep checker
package proj_pkg;

    localparam int N_IN = 14;
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/proj_subset_enum.sv
// rtl/proj_subset_enum.sv - walks every subset of the care mask in ascending order
module proj_subset_enum #(
    parameter int N_IN = 14
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            adv_i,
    input  logic [N_IN-1:0] mask_i,
    output logic [N_IN-1:0] nxt_o,
    output logic            last_o
);

    logic [N_IN-1:0] r_q;
    logic [N_IN-1:0] r_d;

    // Forcing non-care bits to 1 lets the carry ripple straight across them.
    always_comb begin
        nxt_o  = ((r_q | ~mask_i) + N_IN'(1)) & mask_i;
        last_o = (nxt_o == '0);
        r_d    = r_q;
        if (clr_i) begin
            r_d = '0;
        end else if (adv_i) begin
            r_d = nxt_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

endmodule

// File: rtl/proj_sweep_checker.sv
// rtl/proj_sweep_checker.sv - exhaustive sweep of a projected function with onset, mismatch and MISR results
module proj_sweep_checker #(
    parameter int N_IN  = proj_pkg::N_IN,
    parameter int CNT_W = N_IN + 1,
    parameter int SIG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_IN-1:0]  care_mask,
    input  logic [N_IN-1:0]  fixed_val,
    output logic [N_IN-1:0]  vec_o,
    input  logic             y_i,
    input  logic             y_ref_i,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] onset_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             mismatch,
    output logic [N_IN-1:0]  first_mm_vec,
    output logic [SIG_W-1:0] signature
);

    import proj_pkg::*;

    sweep_state_e state_q, state_d;
    logic            enum_clr, enum_adv, enum_last;
    logic [N_IN-1:0] enum_nxt;

    logic [N_IN-1:0]  mask_q, fix_q, vec_q;
    logic             cap_vld_q, cap_y_q, cap_yr_q;
    logic [N_IN-1:0]  cap_vec_q;
    logic [CNT_W-1:0] onset_q, mm_cnt_q;
    logic             mm_q;
    logic [N_IN-1:0]  first_q;
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    proj_subset_enum #(.N_IN(N_IN)) u_enum (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (enum_clr),
        .adv_i  (enum_adv),
        .mask_i (mask_q),
        .nxt_o  (enum_nxt),
        .last_o (enum_last)
    );

    always_comb begin
        state_d  = state_q;
        enum_clr = 1'b0;
        enum_adv = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    enum_clr = 1'b1;
                end
            end
            ST_RUN: begin
                enum_adv = 1'b1;
                if (enum_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        sig_d = (sig_q << 1) ^ (sig_q[SIG_W-1] ? SIG_W'(MISR_POLY) : '0) ^ SIG_W'(cap_y_q);
    end

    // Capture and accumulate are pipelined one edge apart so the projection path gets a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q    <= '0;
            fix_q     <= '0;
            vec_q     <= '0;
            cap_vld_q <= 1'b0;
            cap_y_q   <= 1'b0;
            cap_yr_q  <= 1'b0;
            cap_vec_q <= '0;
            onset_q   <= '0;
            mm_cnt_q  <= '0;
            mm_q      <= 1'b0;
            first_q   <= '0;
            sig_q     <= '0;
        end else begin
            cap_vld_q <= (state_q == ST_RUN);
            if (state_q == ST_RUN) begin
                cap_y_q   <= y_i;
                cap_yr_q  <= y_ref_i;
                cap_vec_q <= vec_q;
                if (!enum_last) begin
                    vec_q <= enum_nxt | (fix_q & ~mask_q);
                end
            end
            if (state_q == ST_IDLE && start) begin
                mask_q   <= care_mask;
                fix_q    <= fixed_val;
                vec_q    <= fixed_val & ~care_mask;
                onset_q  <= '0;
                mm_cnt_q <= '0;
                mm_q     <= 1'b0;
                first_q  <= '0;
                sig_q    <= SIG_W'(MISR_SEED);
            end else if (cap_vld_q) begin
                onset_q <= onset_q + CNT_W'(cap_y_q);
                sig_q   <= sig_d;
                if (cap_y_q != cap_yr_q) begin
                    mm_cnt_q <= mm_cnt_q + CNT_W'(1);
                    if (!mm_q) begin
                        mm_q    <= 1'b1;
                        first_q <= cap_vec_q;
                    end
                end
            end
        end
    end

    assign vec_o        = vec_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign onset_cnt    = onset_q;
    assign mismatch_cnt = mm_cnt_q;
    assign mismatch     = mm_q;
    assign first_mm_vec = first_q;
    assign signature    = sig_q;

endmodule

// File: tb/tb_proj_sweep_checker.sv
// tb/tb_proj_sweep_checker.sv - scoreboard bench for proj_sweep_checker
module tb_proj_sweep_checker;

    typedef struct {
        logic [14:0] onset;
        logic [14:0] mm;
        logic        mism;
        logic [13:0] first;
        logic [15:0] sig;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] care_mask = '0;
    logic [13:0] fixed_val = '0;
    logic [13:0] vec_o;
    logic        y_i, y_ref_i;
    logic        busy, done;
    logic [14:0] onset_cnt, mismatch_cnt;
    logic        mismatch;
    logic [13:0] first_mm_vec;
    logic [15:0] signature;

    int   mode = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [13:0] seen[$];
    logic [13:0] drain_vec;

    always #5 clk = ~clk;

    proj_sweep_checker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .care_mask    (care_mask),
        .fixed_val    (fixed_val),
        .vec_o        (vec_o),
        .y_i          (y_i),
        .y_ref_i      (y_ref_i),
        .busy         (busy),
        .done         (done),
        .onset_cnt    (onset_cnt),
        .mismatch_cnt (mismatch_cnt),
        .mismatch     (mismatch),
        .first_mm_vec (first_mm_vec),
        .signature    (signature)
    );

    function automatic logic ystub(input int md, input logic [13:0] v);
        case (md)
            0, 1:    return v[9];
            3:       return v[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic yrstub(input int md, input logic [13:0] v);
        case (md)
            1:       return ~v[9];
            3:       return (v == 14'h3FFE) ? ~v[0] : v[0];
            default: return ystub(md, v);
        endcase
    endfunction

    always_comb begin
        y_i     = ystub(mode, vec_o);
        y_ref_i = yrstub(mode, vec_o);
    end

    // Reference MISR: scan all 2^14 vectors in ascending order, keep those matching the fixed bits.
    function automatic logic [15:0] model_sig(input logic [13:0] m, input logic [13:0] f, input int md);
        logic [15:0] s;
        logic [13:0] v;
        s = 16'hFFFF;
        for (int i = 0; i < 16384; i++) begin
            v = i[13:0];
            if ((v & ~m) == (f & ~m)) begin
                s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, ystub(md, v)};
            end
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("onset_cnt", 64'(onset_cnt), 64'(e.onset));
                chk("mismatch_cnt", 64'(mismatch_cnt), 64'(e.mm));
                chk("mismatch", 64'(mismatch), 64'(e.mism));
                chk("first_mm_vec", 64'(first_mm_vec), 64'(e.first));
                chk("signature", 64'(signature), 64'(e.sig));
            end
        end
    end

    task automatic run_sweep(input logic [13:0] m, input logic [13:0] f, input int md, input exp_t e,
                             input int pulse_n, input int abort_n, output int done_n);
        int  v_cnt;
        int  n;
        bit  fin;
        v_cnt = 1 << $countones(m);
        seen.delete();
        drain_vec = 'x;
        @(negedge clk);
        mode = md;
        care_mask = m;
        fixed_val = f;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        done_n = -1;
        n = 0;
        fin = 0;
        while (!fin) begin
            @(negedge clk);
            if (n == 0) chk("busy_after_e0", 64'(busy), 64'd1);
            if (n == abort_n) begin
                rst_n = 1'b0;
                #1;
                chk("abort_a", 64'({vec_o, busy, done, mismatch, first_mm_vec}), 64'd0);
                chk("abort_b", 64'({onset_cnt, mismatch_cnt, signature}), 64'd0);
                sb.delete();
                @(posedge clk);
                #1 rst_n = 1'b1;
                fin = 1;
            end else begin
                if (n < v_cnt) seen.push_back(vec_o);
                if (n == v_cnt) drain_vec = vec_o;
                start = (n == pulse_n);
                if (done) begin
                    done_n = n;
                    fin = 1;
                end else if (n > v_cnt + 20) begin
                    checks++;
                    failures++;
                    $display("FAIL done_timeout actual=%0d required=%0d", n, v_cnt + 1);
                    fin = 1;
                end else begin
                    @(posedge clk);
                    n++;
                end
            end
        end
        if (abort_n < 0) begin
            @(negedge clk);
            chk("done_one_cycle", 64'({done, busy}), 64'd0);
        end
    endtask

    initial begin
        exp_t e;
        int   dn;
        repeat (3) @(negedge clk);
        chk("reset_a", 64'({vec_o, busy, done, mismatch, first_mm_vec}), 64'd0);
        chk("reset_b", 64'({onset_cnt, mismatch_cnt, signature}), 64'd0);
        rst_n = 1'b1;

        // y = x9, reference agrees
        e = '{onset: 15'd16, mm: 15'd0, mism: 1'b0, first: 14'h0, sig: model_sig(14'h3E00, 14'h0, 0)};
        run_sweep(14'h3E00, 14'h0000, 0, e, -1, -1, dn);
        chk("done_edges_32", 64'(dn), 64'd33);
        chk("vec_count_32", 64'(seen.size()), 64'd32);

        // reference inverted: every vector mismatches
        e = '{onset: 15'd16, mm: 15'd32, mism: 1'b1, first: 14'h0, sig: model_sig(14'h3E00, 14'h0, 1)};
        run_sweep(14'h3E00, 14'h0000, 1, e, -1, -1, dn);
        chk("done_edges_inv", 64'(dn), 64'd33);

        // empty mask: single vector equal to fixed value
        e = '{onset: 15'd0, mm: 15'd0, mism: 1'b0, first: 14'h0, sig: 16'hEFDF};
        run_sweep(14'h0000, 14'h1234, 2, e, -1, -1, dn);
        chk("done_edges_m0", 64'(dn), 64'd2);
        chk("vec_count_m0", 64'(seen.size()), 64'd1);
        chk("vec_m0", 64'(seen[0]), 64'h1234);

        // two care bits; reference disagrees only at 3FFE
        e = '{onset: 15'd2, mm: 15'd1, mism: 1'b1, first: 14'h3FFE, sig: model_sig(14'h0003, 14'h3FFC, 3)};
        run_sweep(14'h0003, 14'h3FFC, 3, e, -1, -1, dn);
        chk("done_edges_m3", 64'(dn), 64'd5);
        chk("vec_count_m3", 64'(seen.size()), 64'd4);
        chk("vec_seq_0", 64'(seen[0]), 64'h3FFC);
        chk("vec_seq_1", 64'(seen[1]), 64'h3FFD);
        chk("vec_seq_2", 64'(seen[2]), 64'h3FFE);
        chk("vec_seq_3", 64'(seen[3]), 64'h3FFF);
        chk("vec_drain_hold", 64'(drain_vec), 64'h3FFF);
        repeat (4) @(negedge clk);
        chk("results_hold_onset", 64'(onset_cnt), 64'd2);
        chk("results_hold_first", 64'(first_mm_vec), 64'h3FFE);

        // start pulsed mid-sweep must be ignored
        e = '{onset: 15'd16, mm: 15'd0, mism: 1'b0, first: 14'h0, sig: model_sig(14'h3E00, 14'h0, 0)};
        run_sweep(14'h3E00, 14'h0000, 0, e, 10, -1, dn);
        chk("done_edges_pulse", 64'(dn), 64'd33);

        // reset during the 10th vector, then a clean sweep
        run_sweep(14'h3E00, 14'h0000, 0, e, -1, 9, dn);
        @(negedge clk);
        chk("idle_after_abort", 64'(busy), 64'd0);
        run_sweep(14'h3E00, 14'h0000, 0, e, -1, -1, dn);
        chk("done_edges_after_abort", 64'(dn), 64'd33);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/proj_sweep_checker.md
# proj_sweep_checker

Sequential exhaustive-sweep harness for one projected single-output function in the D-reduction flow. It sits directly upstream of a combinational projection netlist and drives its 14-bit input vector. It then consumes that netlist's `y0` and a reference `y0` from the original function. It enumerates every assignment of the cared-for input bits, with all other bits held at fixed values, and reports onset size, mismatch count, first failing vector and a 16-bit response signature.

## Interface
- `N_IN`, default 14: width of the input vector driven to the projection.
- `CNT_W`, default `N_IN+1`: width of the counters; holds 2^N_IN without overflow.
- `SIG_W`, default 16: signature width.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  request a sweep; sampled only in IDLE.
- `care_mask`  in  N_IN  1 = bit is enumerated; sampled at start acceptance.
- `fixed_val`  in  N_IN  value of non-care bits; sampled at start acceptance.
- `vec_o`  out  N_IN  registered vector to projection inputs x0..x13.
- `y_i`  in  1  projection output for current `vec_o`.
- `y_ref_i`  in  1  reference function output for current `vec_o`.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse; results final.
- `onset_cnt`  out  CNT_W  number of vectors with `y_i`=1.
- `mismatch_cnt`  out  CNT_W  number of vectors with `y_i`≠`y_ref_i`.
- `mismatch`  out  1  sticky; at least one mismatch this sweep.
- `first_mm_vec`  out  N_IN  vector of first mismatch; 0 if none.
- `signature`  out  SIG_W  MISR over `y_i`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on `start`. Latch mask and fixed value, clear counters/flags/`first_mm_vec`, seed `signature`=16'hFFFF, subset counter r=0.
  - RUN: `vec_o` = r | (fixed_val & ~mask). Next r = ((r | ~mask) + 1) & mask. When next r = 0 (wrap), go to DRAIN.
  - DRAIN: one cycle; last captured sample is accumulated.
  - DONE: `done`=1 for one cycle, then IDLE.
- Vectors per sweep V = 2^popcount(mask). mask=0 gives exactly one vector (= fixed_val). mask all-ones gives 2^14 vectors in ascending order.
- Capture stage: `y_i`, `y_ref_i` and `vec_o` are registered at the end of each RUN cycle, with a valid bit. Accumulation happens on the next edge.
- Accumulate, when capture is valid:
  - `onset_cnt` += y.
  - If y≠y_ref: `mismatch_cnt` += 1. If `mismatch` was 0, load `first_mm_vec` and set `mismatch`.
  - MISR: sig = (sig<<1) ^ (sig[15] ? 16'h1021 : 0) ^ y.
- `start` during RUN/DRAIN/DONE is ignored. A new sweep cannot begin until IDLE.
- Results hold after DONE until the next accepted start.
- Reset values: `vec_o`=0, `busy`=0, `done`=0, counters=0, `mismatch`=0, `first_mm_vec`=0, `signature`=0, state IDLE.
- Reset asserted mid-sweep aborts immediately to the reset values. No partial result is retained.

## Timing
- Start accepted at edge E0. `vec_o` = vector k during the cycle after edge E0+k-1, for k=1..V.
- The response to vector k is captured at edge E0+k. It is accumulated at edge E0+k+1.
- `done` is high in the cycle after edge E0+V+1. All outputs are final in that cycle.
- `busy` is high from edge E0 through the DONE cycle inclusive, and low on return to IDLE.
- The projection path `vec_o`→`y_i` must close in one clock period. There is no multicycle allowance.
- Throughput: one vector per cycle. Sweep overhead is 2 cycles.

## Structure
- Shared package `proj_pkg`: `N_IN`, MISR polynomial 16'h1021, MISR seed 16'hFFFF, FSM state enum.
- One sub-module `proj_subset_enum`: holds r, computes the masked increment, and flags the last vector. The remainder (FSM, capture stage, accumulators) stays in the top.

## Test plan
- Stub `y_i`=`vec_o[9]`, `y_ref_i`=`y_i`; mask 14'h3E00, fixed 0 → `done` 33 edges after E0; `onset_cnt`=16, `mismatch_cnt`=0, `mismatch`=0.
- Same setup with `y_ref_i`=~`y_i` → `mismatch_cnt`=32, `first_mm_vec`=14'h0000.
- mask=0, fixed 14'h1234, `y_i`=0 → exactly one vector 14'h1234 on `vec_o`; `done` at E0+2; `signature`=16'hEFDF, `onset_cnt`=0.
- mask 14'h0003, fixed 14'h3FFC → `vec_o` sequence 3FFC, 3FFD, 3FFE, 3FFF, then stop.
- `start` pulsed in the middle of a 32-vector sweep → ignored; results identical to the first scenario.
- `rst_n` low at the 10th vector of a sweep → all outputs 0 and IDLE at once. A new start then gives full correct results.
